// File: rtl/gate_dead_time_inserter.sv
// -----------------------------------------------------------------------------
// gate_dead_time_inserter
//
// Three-phase gate driver front end. Each commutation PWM input is registered
// once, then drives an independent per-phase FSM that inserts a programmable
// dead interval between switching off one side of a half bridge and switching
// on the other. A synchronous fault input latches, forces every phase off and
// is counted; the latch is released only by an explicit fault_clear.
//
// Handshake/timing: there is no valid/ready flow here. Every input is sampled
// on the rising edge of clk; every output is a pure decode of registered state,
// so outputs change only just after a rising edge.
//
// Ports
//   clk             single clock, all state updates on its rising edge
//   reset           synchronous, active-low reset
//   enable          high = gate drive permitted
//   pwm_phase_a/b/c commutation PWM per phase, 1 = high side on
//   dead_time       dead interval in clk cycles (0 behaves as 1)
//   fault           active-high overcurrent/driver fault
//   fault_clear     single-cycle request to clear a latched fault
//   gate_ah/al, gate_bh/bl, gate_ch/cl  high/low-side gate commands
//   fault_latched   latched fault state
//   fault_count     saturating count of fault latch events
// -----------------------------------------------------------------------------
module gate_dead_time_inserter #(
    parameter int DEAD_W = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pwm_phase_a,
    input  logic              pwm_phase_b,
    input  logic              pwm_phase_c,
    input  logic [DEAD_W-1:0] dead_time,
    input  logic              fault,
    input  logic              fault_clear,
    output logic              gate_ah,
    output logic              gate_al,
    output logic              gate_bh,
    output logic              gate_bl,
    output logic              gate_ch,
    output logic              gate_cl,
    output logic              fault_latched,
    output logic [FCNT_W-1:0] fault_count
);

    typedef enum logic [2:0] {
        ST_OFF          = 3'd0,
        ST_LOW_ON       = 3'd1,
        ST_DEAD_TO_HIGH = 3'd2,
        ST_HIGH_ON      = 3'd3,
        ST_DEAD_TO_LOW  = 3'd4
    } phase_state_t;

    // Index 0 = phase A, 1 = phase B, 2 = phase C. state_q is the
    // per-phase FSM state and is the signal to probe when observing a phase.
    logic [2:0]        pwm_q;
    phase_state_t      state_q [3];
    phase_state_t      state_d [3];
    logic [DEAD_W-1:0] cnt_q   [3];
    logic [DEAD_W-1:0] cnt_d   [3];
    logic [DEAD_W-1:0] dead_load;

    // A zero dead time still yields one cycle with both sides off.
    assign dead_load = (dead_time == '0) ? DEAD_W'(1) : dead_time;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (fault || !enable) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        // Restart always passes through a dead interval.
                        if (!fault_latched) begin
                            state_d[i] = pwm_q[i] ? ST_DEAD_TO_HIGH : ST_DEAD_TO_LOW;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    ST_LOW_ON: begin
                        if (pwm_q[i]) begin
                            state_d[i] = ST_DEAD_TO_HIGH;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    ST_HIGH_ON: begin
                        if (!pwm_q[i]) begin
                            state_d[i] = ST_DEAD_TO_LOW;
                            cnt_d[i]   = dead_load;
                        end
                    end
                    ST_DEAD_TO_HIGH: begin
                        if (!pwm_q[i]) begin
                            // PWM went back before high side was allowed on.
                            state_d[i] = ST_LOW_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] <= DEAD_W'(1)) begin
                            state_d[i] = ST_HIGH_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DEAD_W'(1);
                        end
                    end
                    ST_DEAD_TO_LOW: begin
                        if (pwm_q[i]) begin
                            state_d[i] = ST_HIGH_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] <= DEAD_W'(1)) begin
                            state_d[i] = ST_LOW_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DEAD_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_q         <= '0;
            fault_latched <= 1'b0;
            fault_count   <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            pwm_q <= {pwm_phase_c, pwm_phase_b, pwm_phase_a};
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            // Fault has priority over clear.
            if (fault) begin
                fault_latched <= 1'b1;
            end else if (fault_clear) begin
                fault_latched <= 1'b0;
            end
            // Count only rising transitions of the latch, saturating.
            if (fault && !fault_latched && (fault_count != '1)) begin
                fault_count <= fault_count + FCNT_W'(1);
            end
        end
    end

    // Each gate is on only in its own ON state, so high and low of one phase
    // can never be on together.
    assign gate_ah = (state_q[0] == ST_HIGH_ON);
    assign gate_al = (state_q[0] == ST_LOW_ON);
    assign gate_bh = (state_q[1] == ST_HIGH_ON);
    assign gate_bl = (state_q[1] == ST_LOW_ON);
    assign gate_ch = (state_q[2] == ST_HIGH_ON);
    assign gate_cl = (state_q[2] == ST_LOW_ON);

endmodule

// File: tb/tb_gate_dead_time_inserter.sv
// -----------------------------------------------------------------------------
// tb_gate_dead_time_inserter
//
// Directed scenarios followed by a randomized run. A behavioural model tracks,
// per phase, which side is on (or none) and how many dead cycles remain before
// the requested side may turn on; every cycle all outputs are compared with it.
// -----------------------------------------------------------------------------
module tb_gate_dead_time_inserter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pwm_phase_a;
    logic       pwm_phase_b;
    logic       pwm_phase_c;
    logic [7:0] dead_time;
    logic       fault;
    logic       fault_clear;
    logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic       fault_latched;
    logic [7:0] fault_count;

    int checks = 0;
    int errors = 0;

    // Model state: m_act = -1 none on, 0 low side on, 1 high side on.
    // m_rem > 0 means a dead interval is running toward side m_tgt.
    int m_act [3];
    int m_tgt [3];
    int m_rem [3];
    bit m_pq  [3];
    bit m_latch;
    int m_cnt;

    gate_dead_time_inserter #(.DEAD_W(8), .FCNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pwm_phase_a  (pwm_phase_a),
        .pwm_phase_b  (pwm_phase_b),
        .pwm_phase_c  (pwm_phase_c),
        .dead_time    (dead_time),
        .fault        (fault),
        .fault_clear  (fault_clear),
        .gate_ah      (gate_ah),
        .gate_al      (gate_al),
        .gate_bh      (gate_bh),
        .gate_bl      (gate_bl),
        .gate_ch      (gate_ch),
        .gate_cl      (gate_cl),
        .fault_latched(fault_latched),
        .fault_count  (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        bit pwm_now [3];
        int dl;
        pwm_now[0] = pwm_phase_a;
        pwm_now[1] = pwm_phase_b;
        pwm_now[2] = pwm_phase_c;
        dl = (dead_time == 8'd0) ? 1 : int'(dead_time);
        if (!reset) begin
            for (int p = 0; p < 3; p++) begin
                m_act[p] = -1; m_tgt[p] = 0; m_rem[p] = 0; m_pq[p] = 1'b0;
            end
            m_latch = 1'b0;
            m_cnt   = 0;
            return;
        end
        for (int p = 0; p < 3; p++) begin
            if (fault || !enable) begin
                m_act[p] = -1;
                m_rem[p] = 0;
            end else if (m_rem[p] > 0) begin
                if (int'(m_pq[p]) != m_tgt[p]) begin
                    m_act[p] = int'(m_pq[p]);
                    m_rem[p] = 0;
                end else if (m_rem[p] == 1) begin
                    m_act[p] = m_tgt[p];
                    m_rem[p] = 0;
                end else begin
                    m_rem[p] = m_rem[p] - 1;
                end
            end else if (m_act[p] == -1) begin
                if (!m_latch) begin
                    m_tgt[p] = int'(m_pq[p]);
                    m_rem[p] = dl;
                end
            end else if (m_act[p] != int'(m_pq[p])) begin
                m_act[p] = -1;
                m_tgt[p] = int'(m_pq[p]);
                m_rem[p] = dl;
            end
        end
        if (fault && !m_latch && m_cnt < 255) m_cnt++;
        if (fault) m_latch = 1'b1;
        else if (fault_clear) m_latch = 1'b0;
        for (int p = 0; p < 3; p++) m_pq[p] = pwm_now[p];
    endtask

    task automatic compare_all();
        check("gate_ah", gate_ah, m_act[0] == 1);
        check("gate_al", gate_al, m_act[0] == 0);
        check("gate_bh", gate_bh, m_act[1] == 1);
        check("gate_bl", gate_bl, m_act[1] == 0);
        check("gate_ch", gate_ch, m_act[2] == 1);
        check("gate_cl", gate_cl, m_act[2] == 0);
        check("fault_latched", fault_latched, m_latch);
        check("fault_count", fault_count, 32'(m_cnt));
        check("overlap_a", gate_ah & gate_al, 0);
        check("overlap_b", gate_bh & gate_bl, 0);
        check("overlap_c", gate_ch & gate_cl, 0);
    endtask

    // One clock: model follows the edge, outputs checked 1ns later; callers
    // then change inputs well away from the next edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        bit ch_seen;
        reset = 1'b0; enable = 1'b0; dead_time = 8'd4;
        pwm_phase_a = 1'b0; pwm_phase_b = 1'b0; pwm_phase_c = 1'b0;
        fault = 1'b0; fault_clear = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        check("rst_count", fault_count, 0);

        // Enable: all phases settle into LOW_ON
        reset = 1'b1; enable = 1'b1;
        repeat (8) step();
        check("settle_al", gate_al, 1);

        // Basic timing: dead_time=4 on phase A
        pwm_phase_a = 1'b1;
        step();                               // E0: pwm_q_a captured
        check("e0_al", gate_al, 1);
        step();                               // E0+1
        check("e1_al_off", gate_al, 0);
        repeat (3) begin
            step();
            check("dead_ah_off", gate_ah, 0);
        end
        step();                               // E0+5
        check("e5_ah_on", gate_ah, 1);

        // Zero dead time on phase B: one empty cycle at each transition
        dead_time = 8'd0;
        for (int k = 0; k < 4; k++) begin
            pwm_phase_b = ~pwm_phase_b;
            step();
            step();
            check("zero_dt_gap", gate_bh | gate_bl, 0);
            step();
            check("zero_dt_on", gate_bh ^ gate_bl, 1);
            step();
        end
        pwm_phase_b = 1'b0;
        repeat (3) step();

        // Abort on phase C with dead_time=10
        dead_time = 8'd10;
        ch_seen = 1'b0;
        pwm_phase_c = 1'b1;
        repeat (3) begin
            step();
            ch_seen |= gate_ch;
        end
        pwm_phase_c = 1'b0;
        step();                               // pwm_q_c falls here
        ch_seen |= gate_ch;
        check("abort_cl_off", gate_cl, 0);
        step();
        ch_seen |= gate_ch;
        check("abort_cl_on", gate_cl, 1);
        repeat (10) begin
            step();
            ch_seen |= gate_ch;
        end
        check("abort_ch_never", ch_seen, 0);

        // Fault while gate_ah is on, then clear and restart through DEAD
        dead_time = 8'd4;
        check("pre_fault_ah", gate_ah, 1);
        fault = 1'b1;
        step();
        fault = 1'b0;
        check("fault_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        check("fault_latch", fault_latched, 1);
        check("fault_cnt1", fault_count, 1);
        enable = 1'b1;
        repeat (3) step();
        check("fault_hold_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        check("clear_latch", fault_latched, 0);
        repeat (4) begin
            step();
            check("restart_dead", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        end
        step();
        check("restart_ah", gate_ah, 1);

        // Simultaneous fault and clear, then counter saturation
        fault = 1'b1; fault_clear = 1'b1;
        step();
        check("fault_wins", fault_latched, 1);
        for (int k = 0; k < 300; k++) begin
            fault = 1'b1; fault_clear = 1'b0;
            step();
            fault = 1'b0; fault_clear = 1'b1;
            step();
        end
        fault_clear = 1'b0;
        check("count_sat", fault_count, 255);
        check("sat_cleared", fault_latched, 0);

        // Randomized operation
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) pwm_phase_a = ~pwm_phase_a;
            if ($urandom_range(0, 5) == 0) pwm_phase_b = ~pwm_phase_b;
            if ($urandom_range(0, 5) == 0) pwm_phase_c = ~pwm_phase_c;
            if ($urandom_range(0, 19) == 0) dead_time = 8'($urandom_range(0, 6));
            enable      = ($urandom_range(0, 49) != 0);
            fault       = ($urandom_range(0, 79) == 0);
            fault_clear = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 149) != 0);
            step();
        end
        fault = 1'b0; fault_clear = 1'b1; reset = 1'b1; enable = 1'b1;
        step();
        fault_clear = 1'b0;

        // Reset during DEAD_TO_HIGH, then restart with dead_time=2
        pwm_phase_a = 1'b0; dead_time = 8'd3;
        repeat (8) step();
        check("pre_rst_al", gate_al, 1);
        dead_time = 8'd10;
        pwm_phase_a = 1'b1;
        repeat (3) step();                    // phase A now mid DEAD_TO_HIGH
        reset = 1'b0;
        step();
        check("mid_rst_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        check("mid_rst_latch", fault_latched, 0);
        check("mid_rst_count", fault_count, 0);
        reset = 1'b1; enable = 1'b0; dead_time = 8'd2;
        pwm_phase_a = 1'b1; pwm_phase_b = 1'b1; pwm_phase_c = 1'b1;
        step();                               // pwm_q settles, FSMs stay OFF
        enable = 1'b1;
        step();                               // OFF exits into DEAD_TO_HIGH
        check("rst_exit_ah", gate_ah, 0);
        step();
        check("rst_dead_ah", gate_ah, 0);
        step();
        check("rst_on_ah", gate_ah, 1);
        check("rst_on_bh", gate_bh, 1);
        check("rst_on_ch", gate_ch, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
